// File: rtl/mips_reg_file.sv
// mips_reg_file: 32x32 MIPS register file, two combinational read ports, one write port, registered debug port
module mips_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);
  localparam int N = 2**ADDR_W;
  logic [DATA_W-1:0] regs [N];
  logic wr_en;
  assign wr_en = we && waddr != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      dbg_data <= '0;
      wr_count <= '0;
    end else begin
      dbg_data <= dbg_addr == '0 ? '0 : regs[dbg_addr];
      if (wr_en) begin
        regs[waddr] <= wdata;
        wr_count <= wr_count + 16'd1;
      end
    end
  // reset also masks the write-through path so reads are 0 while reset is held
  logic byp_ok;
  assign byp_ok = BYPASS_EN && rst_n && wr_en;
  always_comb begin
    rdata1 = raddr1 == '0 ? '0 : (byp_ok && waddr == raddr1) ? wdata : regs[raddr1];
    rdata2 = raddr2 == '0 ? '0 : (byp_ok && waddr == raddr2) ? wdata : regs[raddr2];
  end
endmodule

// File: doc/mips_reg_file.md
Name: mips_reg_file

Overview:
- 32 x 32-bit MIPS general-purpose register file for the single-cycle CPU.
- Sits directly downstream of the 5-bit write-register selector (rt/rd mux), whose output drives waddr.
- Provides two combinational read ports (rs, rt), one synchronous write port and a debug read port.
- Register $0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; register count = 2**ADDR_W.
- BYPASS_EN, 1, when 1, a read of the register being written this cycle returns wdata (write-through).

Ports:
- clk  input  1  system clock; all writes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- raddr1  input  ADDR_W  read port 1 address (rs).
- raddr2  input  ADDR_W  read port 2 address (rt).
- rdata1  output  DATA_W  read port 1 data, combinational.
- rdata2  output  DATA_W  read port 2 data, combinational.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address (from rt/rd selector).
- wdata  input  DATA_W  write data.
- dbg_addr  input  ADDR_W  debug/monitor read address.
- dbg_data  output  DATA_W  debug read data, registered.
- wr_count  output  16  count of committed writes to non-zero registers.

Behaviour:
- Reset: rst_n low asynchronously clears all 32 registers, dbg_data and wr_count to 0. Effect is immediate, without waiting for a clock edge. rdata1/rdata2 therefore read 0 while reset is held.
- Write: on posedge clk with rst_n high, we=1 and waddr!=0, regs[waddr] <= wdata and wr_count increments by 1.
- Write to $0: we=1 with waddr=0 leaves storage unchanged and does not increment wr_count.
- wr_count wraps 0xFFFF -> 0x0000.
- Reads: rdata1 = 0 if raddr1==0, else regs[raddr1]. rdata2 is the same function of raddr2. Both are purely combinational; there is no clock latency.
- Bypass (BYPASS_EN=1): if we=1, waddr!=0 and raddrN==waddr, rdataN = wdata in the same cycle.
- Bypass off (BYPASS_EN=0): rdataN returns the old value until the edge.
- Both read ports may address the same register at once; both return the identical value.
- Debug: on each posedge clk, dbg_data <= (dbg_addr==0) ? 0 : regs[dbg_addr]. This is a 1-cycle latency and reflects the pre-edge contents, so it never bypasses.
- Reset asserted mid-write: reset dominates. A write coinciding with the release edge is not performed if rst_n is still low at that edge.
- Reset released between edges: the first write occurs at the next rising edge with rst_n high.
- X on waddr while we=0 has no effect on storage.

Test Plan:
- Reset then read: assert rst_n=0 with regs preloaded by prior writes -> rdata1/rdata2 for raddr 1..31 all 0x00000000 immediately; wr_count=0.
- Basic write/read: we=1, waddr=8, wdata=0xDEADBEEF, one edge -> raddr1=8 gives 0xDEADBEEF; wr_count=1; dbg_addr=8 gives dbg_data=0xDEADBEEF one edge later.
- $0 protection: we=1, waddr=0, wdata=0xFFFFFFFF -> rdata1 at raddr1=0 stays 0; wr_count unchanged.
- Bypass, BYPASS_EN=1: same cycle we=1, waddr=5, wdata=0x12345678, raddr1=raddr2=5 -> both rdata = 0x12345678 before the edge. With BYPASS_EN=0 -> old value before the edge, new value after it.
- Async reset mid-operation: write 0xA5A5A5A5 to $31, then drop rst_n between edges -> rdata at $31 becomes 0 without a clock edge. A write with rst_n still low at the edge is ignored.
- Counter wrap: 65536 writes to $1 -> wr_count returns to 0x0000, and $1 holds the last wdata.
